// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the game sequencer: state encodings, screen
// constants and the LFSR seed/taps with a one-step helper.
package game_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PLAY  = 3'd1,
      ST_PAUSE = 3'd2,
      ST_HIT   = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   localparam int unsigned H_VIS = 640;
   localparam int unsigned V_VIS = 480;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Taps 16,14,13,11 -> bits 15,13,12,10 of a left-shifting register.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // One Fibonacci step: shift left, feed back the parity of the tapped bits.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/game_ctrl_lfsr16.sv
// 16-bit maximal-length Fibonacci LFSR used for spawn positions.
// Ports: i_clk clock, i_rst async active-high reset, i_en advance enable,
//        o_lfsr current register state (never zero).
module game_ctrl_lfsr16
   import game_ctrl_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_en,
   output logic [15:0] o_lfsr
);

   // Nonzero seed plus primitive polynomial keeps the register off zero.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)     o_lfsr <= LFSR_SEED;
      else if (i_en) o_lfsr <= lfsr_next(o_lfsr);
   end

endmodule

// File: rtl/game_ctrl.sv
// Game-level sequencer for the flyer display: gates object animation,
// settles per-frame collisions, tracks lives/score and schedules spawns.
// Ports: i_clk, i_rst (async, active-high), i_pix_stb, i_animate, i_start,
//        i_pause, i_ship_px, i_bullet_px, i_enemy_px; outputs o_state, o_run,
//        o_flash, o_lives, o_score, o_ship_hit, o_enemy_kill, o_spawn,
//        o_spawn_x.
// Build option: GAME_CTRL_RAMP_EN shortens the spawn interval as score grows.
module game_ctrl
   import game_ctrl_pkg::*;
#(
   parameter int unsigned LIVES        = 3,
   parameter int unsigned KILL_PTS     = 10,
   parameter int unsigned SCORE_W      = 12,
   parameter int unsigned HIT_FRAMES   = 32,
   parameter int unsigned SPAWN_FRAMES = 60,
   parameter int unsigned MIN_SPAWN    = 20,
   parameter int unsigned SPAWN_MIN    = 40
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_pix_stb,
   input  logic               i_animate,
   input  logic               i_start,
   input  logic               i_pause,
   input  logic               i_ship_px,
   input  logic               i_bullet_px,
   input  logic               i_enemy_px,
   output logic [2:0]         o_state,
   output logic               o_run,
   output logic               o_flash,
   output logic [1:0]         o_lives,
   output logic [SCORE_W-1:0] o_score,
   output logic               o_ship_hit,
   output logic               o_enemy_kill,
   output logic               o_spawn,
   output logic [9:0]         o_spawn_x
);

   localparam int unsigned FC_W = $clog2(SPAWN_FRAMES + 1);
   localparam int unsigned HC_W = ($clog2(HIT_FRAMES) < 3) ? 3 : $clog2(HIT_FRAMES);

   state_t               state_q, state_d;
   logic                 start_q, pause_q, start_e, pause_e;
   logic                 ship_f_q, ship_f_d, kill_f_q, kill_f_d;
   logic [1:0]           lives_q, lives_d;
   logic [SCORE_W-1:0]   score_q, score_d, score_sat;
   logic [SCORE_W:0]     score_sum;
   logic [FC_W-1:0]      fc_q, fc_d, lim_c;
   logic [HC_W-1:0]      hc_q, hc_d;
   logic                 run_q, run_d, flash_q, flash_d;
   logic                 hit_p_q, hit_p_d, kill_p_q, kill_p_d, spawn_q, spawn_d;
   logic [9:0]           spawn_x_q, spawn_x_d;
   logic [15:0]          lfsr;
   logic                 lfsr_en;
   logic                 unused_lfsr_hi;

   assign start_e = i_start & ~start_q;
   assign pause_e = i_pause & ~pause_q;

   // Carry out of the add means the score would wrap: pin it at all-ones.
   assign score_sum = {1'b0, score_q} + (SCORE_W+1)'(KILL_PTS);
   assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

   assign lfsr_en        = (state_q != ST_PAUSE);
   assign unused_lfsr_hi = ^lfsr[15:9];

   game_ctrl_lfsr16 u_lfsr (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (lfsr_en),
      .o_lfsr (lfsr)
   );

`ifdef GAME_CTRL_RAMP_EN
   logic [FC_W-1:0]    lim_q, lim_d, ramp_lim;
   logic [SCORE_W-1:0] ramp_dec;

   // Interval shrinks by one frame per 32 points, floored at MIN_SPAWN.
   always_comb begin
      ramp_dec = score_q >> 5;
      if (32'(ramp_dec) + MIN_SPAWN >= SPAWN_FRAMES) ramp_lim = FC_W'(MIN_SPAWN);
      else                                           ramp_lim = FC_W'(SPAWN_FRAMES - 32'(ramp_dec));
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) lim_q <= FC_W'(SPAWN_FRAMES);
      else       lim_q <= lim_d;
   end

   assign lim_c = lim_q;
`else
   assign lim_c = FC_W'(SPAWN_FRAMES);
`endif

   // State and datapath registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         start_q   <= 1'b0;
         pause_q   <= 1'b0;
         ship_f_q  <= 1'b0;
         kill_f_q  <= 1'b0;
         lives_q   <= 2'(LIVES);
         score_q   <= '0;
         fc_q      <= '0;
         hc_q      <= '0;
         run_q     <= 1'b0;
         flash_q   <= 1'b0;
         hit_p_q   <= 1'b0;
         kill_p_q  <= 1'b0;
         spawn_q   <= 1'b0;
         spawn_x_q <= '0;
      end else begin
         state_q   <= state_d;
         start_q   <= i_start;
         pause_q   <= i_pause;
         ship_f_q  <= ship_f_d;
         kill_f_q  <= kill_f_d;
         lives_q   <= lives_d;
         score_q   <= score_d;
         fc_q      <= fc_d;
         hc_q      <= hc_d;
         run_q     <= run_d;
         flash_q   <= flash_d;
         hit_p_q   <= hit_p_d;
         kill_p_q  <= kill_p_d;
         spawn_q   <= spawn_d;
         spawn_x_q <= spawn_x_d;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d   = state_q;
      ship_f_d  = ship_f_q;
      kill_f_d  = kill_f_q;
      lives_d   = lives_q;
      score_d   = score_q;
      fc_d      = fc_q;
      hc_d      = hc_q;
      spawn_x_d = spawn_x_q;
      hit_p_d   = 1'b0;
      kill_p_d  = 1'b0;
      spawn_d   = 1'b0;
`ifdef GAME_CTRL_RAMP_EN
      lim_d     = lim_q;
`endif

      unique case (state_q)
         ST_IDLE, ST_OVER: begin
            ship_f_d = 1'b0;
            kill_f_d = 1'b0;
            if (start_e) begin
               state_d = ST_PLAY;
               lives_d = 2'(LIVES);
               score_d = '0;
               fc_d    = '0;
`ifdef GAME_CTRL_RAMP_EN
               lim_d   = FC_W'(SPAWN_FRAMES);
`endif
            end
         end
         ST_PLAY: begin
            if (i_animate) begin
               // Settle the frame; a pixel hit in this same cycle is dropped.
               ship_f_d = 1'b0;
               kill_f_d = 1'b0;
               if (kill_f_q) begin
                  score_d  = score_sat;
                  kill_p_d = 1'b1;
               end
               if (fc_q == lim_c - FC_W'(1)) begin
                  fc_d      = '0;
                  spawn_d   = 1'b1;
                  spawn_x_d = 10'(SPAWN_MIN) + 10'(lfsr[8:0]);
`ifdef GAME_CTRL_RAMP_EN
                  lim_d     = ramp_lim;
`endif
               end else begin
                  fc_d = fc_q + FC_W'(1);
               end
               // A ship hit outranks a coincident pause request.
               if (ship_f_q) begin
                  hit_p_d = 1'b1;
                  if (lives_q == 2'd1) begin
                     lives_d = '0;
                     state_d = ST_OVER;
                  end else begin
                     lives_d = lives_q - 2'd1;
                     state_d = ST_HIT;
                     hc_d    = HC_W'(HIT_FRAMES - 1);
                  end
               end else if (pause_e) begin
                  state_d = ST_PAUSE;
               end
            end else begin
               if (i_pix_stb) begin
                  ship_f_d = ship_f_q | (i_ship_px & i_enemy_px);
                  kill_f_d = kill_f_q | (i_bullet_px & i_enemy_px);
               end
               if (pause_e) state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (pause_e) state_d = ST_PLAY;
         end
         ST_HIT: begin
            ship_f_d = 1'b0;
            kill_f_d = 1'b0;
            if (i_animate) begin
               if (hc_q == '0) state_d = ST_PLAY;
               else            hc_d    = hc_q - HC_W'(1);
            end
         end
         default: begin
            state_d  = ST_IDLE;
            ship_f_d = 1'b0;
            kill_f_d = 1'b0;
         end
      endcase

      run_d   = (state_d == ST_PLAY);
      flash_d = (state_d == ST_HIT) & hc_d[2];
   end

   assign o_state      = state_q;
   assign o_run        = run_q;
   assign o_flash      = flash_q;
   assign o_lives      = lives_q;
   assign o_score      = score_q;
   assign o_ship_hit   = hit_p_q;
   assign o_enemy_kill = kill_p_q;
   assign o_spawn      = spawn_q;
   assign o_spawn_x    = spawn_x_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: a frame-level reference model compared
// against the DUT every cycle, plus hand-computed checkpoints.
module tb_game_ctrl;

   localparam int LIVES        = 3;
   localparam int KILL_PTS     = 10;
   localparam int SCORE_W      = 12;
   localparam int HIT_FRAMES   = 32;
   localparam int SPAWN_FRAMES = 60;
   localparam int MIN_SPAWN    = 20;
   localparam int SPAWN_MIN    = 40;
   localparam int SCORE_MAX    = (1 << SCORE_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pix_stb = 1'b0, animate = 1'b0, start = 1'b0, pause = 1'b0;
   logic ship_px = 1'b0, bullet_px = 1'b0, enemy_px = 1'b0;

   logic [2:0]         o_state;
   logic               o_run, o_flash, o_ship_hit, o_enemy_kill, o_spawn;
   logic [1:0]         o_lives;
   logic [SCORE_W-1:0] o_score;
   logic [9:0]         o_spawn_x;

   int n_checks = 0;
   int n_errors = 0;

   game_ctrl #(
      .LIVES(LIVES), .KILL_PTS(KILL_PTS), .SCORE_W(SCORE_W), .HIT_FRAMES(HIT_FRAMES),
      .SPAWN_FRAMES(SPAWN_FRAMES), .MIN_SPAWN(MIN_SPAWN), .SPAWN_MIN(SPAWN_MIN)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_pix_stb(pix_stb), .i_animate(animate),
      .i_start(start), .i_pause(pause), .i_ship_px(ship_px),
      .i_bullet_px(bullet_px), .i_enemy_px(enemy_px),
      .o_state(o_state), .o_run(o_run), .o_flash(o_flash), .o_lives(o_lives),
      .o_score(o_score), .o_ship_hit(o_ship_hit), .o_enemy_kill(o_enemy_kill),
      .o_spawn(o_spawn), .o_spawn_x(o_spawn_x)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (game rules, one step per clock) ----
   int   m_state, m_lives, m_score, m_fc, m_hc, m_lim, m_spawn_x, score_pre;
   bit   m_run, m_flash, m_hit_p, m_kill_p, m_spawn, m_ship_f, m_kill_f;
   bit   m_start_q, m_pause_q, st_e, pa_e;
   logic [15:0] m_lfsr, lfsr_now;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_state = 0; m_lives = LIVES; m_score = 0; m_fc = 0; m_hc = 0;
         m_lim = SPAWN_FRAMES; m_spawn_x = 0; m_run = 0; m_flash = 0;
         m_hit_p = 0; m_kill_p = 0; m_spawn = 0; m_ship_f = 0; m_kill_f = 0;
         m_start_q = 0; m_pause_q = 0; m_lfsr = 16'hACE1;
      end else begin
         st_e = start && !m_start_q;
         pa_e = pause && !m_pause_q;
         m_start_q = start;
         m_pause_q = pause;
         lfsr_now = m_lfsr;
         if (m_state != 2)
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
         m_hit_p = 0; m_kill_p = 0; m_spawn = 0;
         case (m_state)
            0, 4: begin
               m_ship_f = 0; m_kill_f = 0;
               if (st_e) begin
                  m_state = 1; m_lives = LIVES; m_score = 0; m_fc = 0; m_lim = SPAWN_FRAMES;
               end
            end
            1: begin
               if (animate) begin
                  score_pre = m_score;
                  if (m_kill_f) begin
                     m_score  = (m_score + KILL_PTS > SCORE_MAX) ? SCORE_MAX : m_score + KILL_PTS;
                     m_kill_p = 1;
                  end
                  m_fc++;
                  if (m_fc == m_lim) begin
                     m_fc = 0;
                     m_spawn = 1;
                     m_spawn_x = SPAWN_MIN + int'(lfsr_now[8:0]);
`ifdef GAME_CTRL_RAMP_EN
                     m_lim = SPAWN_FRAMES - score_pre / 32;
                     if (m_lim < MIN_SPAWN) m_lim = MIN_SPAWN;
`endif
                  end
                  if (m_ship_f) begin
                     m_hit_p = 1;
                     m_lives--;
                     if (m_lives == 0) m_state = 4;
                     else begin m_state = 3; m_hc = HIT_FRAMES - 1; end
                  end else if (pa_e) begin
                     m_state = 2;
                  end
                  m_ship_f = 0; m_kill_f = 0;
               end else begin
                  if (pix_stb && ship_px && enemy_px)   m_ship_f = 1;
                  if (pix_stb && bullet_px && enemy_px) m_kill_f = 1;
                  if (pa_e) m_state = 2;
               end
            end
            2: if (pa_e) m_state = 1;
            3: begin
               m_ship_f = 0; m_kill_f = 0;
               if (animate) begin
                  if (m_hc == 0) m_state = 1;
                  else           m_hc--;
               end
            end
            default: m_state = 0;
         endcase
         m_run   = (m_state == 1);
         m_flash = (m_state == 3) && ((m_hc / 4) % 2 == 1);
      end
   end

   // ---------------- per-cycle compare and event counters ----------------
   int kill_cnt = 0, hit_cnt = 0, spawn_cnt = 0, last_x = 0;

   always @(negedge clk) begin
      if (!rst) begin
         check("state", 32'(o_state), 32'(m_state));
         check("run", 32'(o_run), 32'(m_run));
         check("flash", 32'(o_flash), 32'(m_flash));
         check("lives", 32'(o_lives), 32'(m_lives));
         check("score", 32'(o_score), 32'(m_score));
         check("ship_hit", 32'(o_ship_hit), 32'(m_hit_p));
         check("enemy_kill", 32'(o_enemy_kill), 32'(m_kill_p));
         check("spawn", 32'(o_spawn), 32'(m_spawn));
         if (m_spawn) check("spawn_x", 32'(o_spawn_x), 32'(m_spawn_x));
         if (o_enemy_kill === 1'b1) kill_cnt++;
         if (o_ship_hit === 1'b1)   hit_cnt++;
         if (o_spawn === 1'b1) begin
            spawn_cnt++;
            last_x = int'(o_spawn_x);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   // One short frame: a strobed pixel, a gap, the animate pulse, two idles.
   task automatic frame(input bit sh, input bit bu, input bit en, input bit pz);
      pix_stb = 1; ship_px = sh; bullet_px = bu; enemy_px = en; tick();
      pix_stb = 0; ship_px = 0; bullet_px = 0; enemy_px = 0;    tick();
      animate = 1; pause = pz;                                  tick();
      animate = 0; pause = 0;                                   tick();
      tick();
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame(0, 0, 0, 0);
   endtask

   task automatic press_start();
      start = 1; tick();
      start = 0; tick();
   endtask

   task automatic press_pause();
      pause = 1; tick();
      pause = 0; tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenario ----------------
   int k0, h0, s0;

   initial begin
      repeat (3) tick();
      rst = 0;
      tick();
      check("rst_state", 32'(o_state), 0);
      check("rst_run", 32'(o_run), 0);
      check("rst_lives", 32'(o_lives), 3);
      check("rst_score", 32'(o_score), 0);

      // Start a game.
      press_start();
      check("start_state", 32'(o_state), 1);
      check("start_run", 32'(o_run), 1);
      check("start_lives", 32'(o_lives), 3);
      check("start_score", 32'(o_score), 0);

      // One kill, then three quiet frames.
      k0 = kill_cnt;
      frame(0, 1, 1, 0);
      check("kill_pulses", 32'(kill_cnt - k0), 1);
      check("kill_score", 32'(o_score), 10);
      frames(3);
      check("quiet_score", 32'(o_score), 10);

      // First ship hit and the HIT blink pattern.
      h0 = hit_cnt;
      frame(1, 0, 1, 0);
      check("hit1_pulses", 32'(hit_cnt - h0), 1);
      check("hit1_lives", 32'(o_lives), 2);
      check("hit1_state", 32'(o_state), 3);
      check("hit1_run", 32'(o_run), 0);
      check("flash_f0", 32'(o_flash), 1);
      frames(4);
      check("flash_f4", 32'(o_flash), 0);
      frames(4);
      check("flash_f8", 32'(o_flash), 1);
      frames(24);
      check("hit1_end_state", 32'(o_state), 1);
      check("hit1_end_flash", 32'(o_flash), 0);

      // Second hit, recover, then last life lost together with a kill.
      frame(1, 0, 1, 0);
      check("hit2_lives", 32'(o_lives), 1);
      frames(32);
      check("hit2_end_state", 32'(o_state), 1);
      pix_stb = 1; ship_px = 1; enemy_px = 1; tick();
      bullet_px = 1; ship_px = 0; tick();
      pix_stb = 0; bullet_px = 0; enemy_px = 0;
      frame(0, 0, 0, 0);
      check("over_lives", 32'(o_lives), 0);
      check("over_score", 32'(o_score), 20);
      check("over_state", 32'(o_state), 4);
      check("over_run", 32'(o_run), 0);
      press_start();
      check("restart_state", 32'(o_state), 1);
      check("restart_lives", 32'(o_lives), 3);
      check("restart_score", 32'(o_score), 0);

      // Spawn on the 60th frame of the new game.
      s0 = spawn_cnt;
      frames(59);
      check("spawn_none_59", 32'(spawn_cnt - s0), 0);
      frames(1);
      check("spawn_at_60", 32'(spawn_cnt - s0), 1);
      check("spawn_x_range", 32'(last_x >= 40 && last_x <= 551), 1);

      // Pause coinciding with a kill frame: frame settles, then pause holds.
      s0 = spawn_cnt;
      frames(30);
      frame(0, 1, 1, 1);
      check("pause_state", 32'(o_state), 2);
      check("pause_score", 32'(o_score), 10);
      press_start();
      check("pause_start_ignored", 32'(o_state), 2);
      frames(100);
      check("pause_no_spawn", 32'(spawn_cnt - s0), 0);
      press_pause();
      check("resume_state", 32'(o_state), 1);
      frames(28);
      check("resume_none_59", 32'(spawn_cnt - s0), 0);
      frames(1);
      check("resume_spawn", 32'(spawn_cnt - s0), 1);

      // Drive the score into saturation.
      for (int i = 0; i < 408; i++) frame(0, 1, 1, 0);
      check("score_4090", 32'(o_score), 4090);
      frame(0, 1, 1, 0);
      check("score_sat", 32'(o_score), 4095);
      k0 = kill_cnt;
      frame(0, 1, 1, 0);
      check("score_stay", 32'(o_score), 4095);
      check("sat_kill_pulse", 32'(kill_cnt - k0), 1);

      // Reset with a pending ship flag: next animate is seen from IDLE.
      h0 = hit_cnt;
      pix_stb = 1; ship_px = 1; enemy_px = 1; tick();
      pix_stb = 0; ship_px = 0; enemy_px = 0;
      rst = 1; tick();
      rst = 0; tick();
      animate = 1; tick();
      animate = 0; tick();
      check("midrst_state", 32'(o_state), 0);
      check("midrst_lives", 32'(o_lives), 3);
      check("midrst_score", 32'(o_score), 0);
      check("midrst_no_hit", 32'(hit_cnt - h0), 0);
      press_start();
      frame(0, 0, 0, 0);
      check("midrst_play_lives", 32'(o_lives), 3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
